aes_text_out_unloader: RTL
==========================

Name: aes_text_out_unloader

Overview:
- Reader for the aes_cipher_top result: captures the 128-bit text_out word when the cipher signals done.
- Streams the captured word out as a sequence of narrow beats over a valid/ready interface.
- Sits between aes_cipher_top and the downstream byte-stream consumer (DMA or UART bridge).
- Decouples the cipher's single-cycle done pulse from a slow or stalling sink, and flags any result lost to overrun.

Parameters:
- TEXT_W, 128, width of text_out (must be a multiple of BEAT_W).
- BEAT_W, 8, width of each output beat.
- MSB_FIRST, 1: 1 = first beat is text_out[TEXT_W-1 -: BEAT_W]; 0 = first beat is text_out[BEAT_W-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- done  in  1  cipher completion pulse; text_out is valid in the same cycle.
- text_out  in  TEXT_W  cipher result.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts beat.
- out_data  out  BEAT_W  current beat.
- out_last  out  1  current beat is the final beat of the block.
- busy  out  1  a block is held or being streamed.
- overrun  out  1  sticky: a done arrived while busy and its block was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- NBEATS = TEXT_W/BEAT_W (16 by default). Beat counter width is clog2(NBEATS).
- Reset (rst low, asynchronous):
  - state = IDLE; shift register = 0; count = 0.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0, overrun = 0.
- Registers: shift register (TEXT_W), beat count, state, overrun.
- IDLE:
  - done=1 -> load text_out into the shift register, count = NBEATS-1, go to SEND.
  - The first beat is presented with out_valid=1 on the next cycle (capture-to-valid latency 1 cycle).
- SEND:
  - out_valid=1 and busy=1.
  - out_data is the current head of the shift register, MSB or LSB end per MSB_FIRST.
  - out_last = (count == 0).
  - A transfer occurs on a cycle where out_valid & out_ready; on a transfer:
    - shift by BEAT_W toward the head (zero-fill) and decrement count.
    - transfer with count==0 -> go to IDLE.
  - No transfer -> out_data, out_last and count hold stable (AXI-style: valid must not drop, data must not change until accepted).
- Back-to-back: done=1 in the same cycle as the final-beat transfer.
  - The new block is captured; state stays SEND with count = NBEATS-1.
  - out_valid stays 1 with no bubble; no overrun.
- Overrun: done=1 in SEND, other than on the final-beat transfer cycle.
  - The new text_out is ignored; overrun is set to 1 next cycle.
  - The block in progress continues unaffected.
- overrun clears only on clr_overrun=1. Simultaneous set and clear -> set wins.
- busy = (state == SEND).
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-stream:
  - Immediately forces IDLE with all outputs 0; the partial block is discarded.
  - After release, no beat is emitted until a fresh done.
- No combinational path from done or text_out to any output. out_ready affects only next-state logic.

Test Plan:
- Single block, MSB_FIRST=1, out_ready held 1, text_out=128'h00112233_44556677_8899AABB_CCDDEEFF, done pulse at cycle 0.
  -> out_valid from cycle 1 to cycle 16.
  -> out_data 00,11,22,...,FF; out_last only on the FF beat.
  -> busy falls at cycle 17.
- Backpressure: same block, out_ready toggling 1,0,0,1,...
  -> out_data holds its value across stalled cycles.
  -> 16 beats total, byte order identical to the previous scenario.
- Back-to-back: second done with text_out=128'hA5...A5 on the cycle the FF beat is accepted.
  -> next cycle out_data=A5 with out_valid continuous (no idle cycle).
  -> overrun stays 0.
- Overrun: done at beat 5 of a stream.
  -> stream completes with the original bytes.
  -> overrun=1 from the following cycle and stays 1.
  -> clr_overrun=1 clears it to 0; clr_overrun with a simultaneous overrun event leaves it 1.
- Reset mid-stream: rst low at beat 7.
  -> out_valid, busy, out_data, out_last all 0 asynchronously.
  -> after release, no out_valid until the next done, whose block streams fully from its first byte.
- MSB_FIRST=0, text_out=128'h0F0E...0100.
  -> beats 00,01,...,0F; out_last on 0F.

Source files
------------

// File: rtl/aes_text_out_unloader.sv
// Captures the aes_cipher_top result on done and streams it out as
// BEAT_W-wide valid/ready beats, flagging blocks dropped while busy.
module aes_text_out_unloader #(
    parameter int TEXT_W    = 128,
    parameter int BEAT_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [TEXT_W-1:0] text_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int NBEATS = TEXT_W / BEAT_W;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NBEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [TEXT_W-1:0] sreg;
    logic [TEXT_W-1:0] sreg_n;
    logic [TEXT_W-1:0] shifted;
    logic [BEAT_W-1:0] head;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic              ovr;
    logic              ovr_n;
    logic              xfer;
    logic              fin;

    always_comb begin
        if (MSB_FIRST != 0) begin
            head    = sreg[TEXT_W-1 -: BEAT_W];
            shifted = sreg << BEAT_W;
        end else begin
            head    = sreg[BEAT_W-1:0];
            shifted = sreg >> BEAT_W;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            ovr   <= 1'b0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
            ovr   <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        ovr_n   = ovr;
        xfer    = (state == SEND) && out_ready;
        fin     = xfer && (cnt == '0);
        unique case (state)
            IDLE: begin
                if (done) begin
                    sreg_n  = text_out;
                    cnt_n   = LAST_CNT;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (fin) begin
                    // a done on the final accepted beat chains without a bubble
                    if (done) begin
                        sreg_n = text_out;
                        cnt_n  = LAST_CNT;
                    end else begin
                        sreg_n  = shifted;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (xfer) begin
                    sreg_n = shifted;
                    cnt_n  = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (done && (state == SEND) && !fin) begin
            ovr_n = 1'b1;
        end else if (clr_overrun) begin
            ovr_n = 1'b0;
        end
    end

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_data  = (state == SEND) ? head : '0;
    assign out_last  = (state == SEND) && (cnt == '0);
    assign overrun   = ovr;

endmodule
